// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared tag encoding and parameter defaults for the RAM arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ID_NONE = 2'd0,
    ID_VGA  = 2'd1,
    ID_CPU  = 2'd2,
    ID_DMA  = 2'd3
  } id_e;

  localparam logic [15:0] VBASE_DEF   = 16'h4000;
  localparam int          RAM_LAT_DEF = 1;
  localparam int          DMA_AGE_DEF = 15;

endpackage

// File: rtl/mem_arb_rd_tag_pipe.sv
// rtl/mem_arb_rd_tag_pipe.sv - fixed-depth shift register carrying read tags alongside RAM latency
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk_i,
  input  logic       clear_i,
  input  logic [1:0] tag_i,
  output logic [1:0] tag_o
);

  logic [1:0] pipe_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= ID_NONE;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - VGA/CPU/DMA arbiter for the 64 KB RAM with read-data return routing and CPU stall
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter logic [15:0] VBASE   = VBASE_DEF,
  parameter int          RAM_LAT = RAM_LAT_DEF,
  parameter int          DMA_AGE = DMA_AGE_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vga_req,
  input  logic [12:0] vga_a,
  output logic        vga_ack,
  output logic        vga_rdy,
  output logic [7:0]  vga_q,
  input  logic        cpu_req,
  input  logic        cpu_w,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d,
  output logic        cpu_ack,
  output logic        cpu_rdy,
  output logic [7:0]  cpu_q,
  output logic        cpu_ce,
  input  logic        dma_req,
  input  logic        dma_w,
  input  logic [15:0] dma_a,
  input  logic [7:0]  dma_d,
  output logic        dma_ack,
  output logic        dma_rdy,
  output logic [7:0]  dma_q,
  output logic [15:0] ram_a,
  output logic [7:0]  ram_d,
  output logic        ram_w,
  input  logic [7:0]  ram_q
);

  logic        gnt_vga, gnt_cpu, gnt_dma;
  logic [7:0]  age_q, age_d;
  logic [15:0] ram_a_q, ram_a_d;
  logic [7:0]  ram_d_q, ram_d_d;
  logic        ram_w_q, ram_w_d;
  logic [1:0]  tag_q, tag_d, tag_ret;

  // A starved DMA port jumps ahead of the CPU for exactly one grant.
  always_comb begin
    gnt_vga = vga_req;
    gnt_cpu = 1'b0;
    gnt_dma = 1'b0;
    if (!vga_req) begin
      if (dma_req && age_q == 8'(DMA_AGE)) gnt_dma = 1'b1;
      else if (cpu_req)                    gnt_cpu = 1'b1;
      else                                 gnt_dma = dma_req;
    end
  end

  always_comb begin
    ram_a_d = ram_a_q;
    ram_d_d = ram_d_q;
    ram_w_d = 1'b0;
    tag_d   = ID_NONE;
    if (gnt_vga) begin
      ram_a_d = VBASE | {3'b000, vga_a};
      tag_d   = ID_VGA;
    end else if (gnt_cpu) begin
      ram_a_d = cpu_a;
      ram_d_d = cpu_d;
      ram_w_d = cpu_w;
      tag_d   = cpu_w ? ID_NONE : ID_CPU;
    end else if (gnt_dma) begin
      ram_a_d = dma_a;
      ram_d_d = dma_d;
      ram_w_d = dma_w;
      tag_d   = dma_w ? ID_NONE : ID_DMA;
    end

    if (!dma_req || gnt_dma)       age_d = 8'd0;
    else if (age_q < 8'(DMA_AGE))  age_d = age_q + 8'd1;
    else                           age_d = age_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ram_a_q <= 16'h0000;
      ram_d_q <= 8'h00;
      ram_w_q <= 1'b0;
      tag_q   <= ID_NONE;
      age_q   <= 8'd0;
    end else begin
      ram_a_q <= ram_a_d;
      ram_d_q <= ram_d_d;
      ram_w_q <= ram_w_d;
      tag_q   <= tag_d;
      age_q   <= age_d;
    end
  end

  // tag_q already covers the command-register stage, so the pipe only spans the RAM itself.
  rd_tag_pipe #(.DEPTH(RAM_LAT)) u_tag_pipe (
    .clk_i   (clock),
    .clear_i (reset),
    .tag_i   (tag_q),
    .tag_o   (tag_ret)
  );

  assign vga_ack = gnt_vga & ~reset;
  assign cpu_ack = gnt_cpu & ~reset;
  assign dma_ack = gnt_dma & ~reset;

  assign vga_rdy = ~reset & (tag_ret == ID_VGA);
  assign cpu_rdy = ~reset & (tag_ret == ID_CPU);
  assign dma_rdy = ~reset & (tag_ret == ID_DMA);

  assign vga_q = vga_rdy ? ram_q : 8'h00;
  assign cpu_q = cpu_rdy ? ram_q : 8'h00;
  assign dma_q = dma_rdy ? ram_q : 8'h00;

  assign ram_a = ram_a_q;
  assign ram_d = ram_d_q;
  assign ram_w = ram_w_q;

  assign cpu_ce = reset | ~cpu_req | (cpu_ack & cpu_w) | cpu_rdy;

endmodule
